aes_core_arbiter: RTL
=====================

# aes_core_arbiter

Round-robin scheduler that shares one iterative AES-128 encryption core among NREQ requesters. Each requester hands over a plaintext/key pair with a valid/ready handshake. The arbiter latches the pair, launches the core with a one-cycle start pulse, and waits for the core's done. It then captures the ciphertext and returns it to the owning requester with a valid/ready response handshake. It sits between the requester fabric and the AES top-level core; the core itself is unchanged.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 64: watchdog limit in cycles spent in BUSY. Used only when the macro is defined.
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- req_valid  in  NREQ: requester i has a job.
- req_ready  out  NREQ: one-hot, high for one cycle on acceptance.
- req_data  in  NREQ*128: plaintext; requester i occupies bits [128i+127:128i].
- req_key  in  NREQ*128: key; same packing as req_data.
- resp_valid  out  NREQ: one-hot; result pending for requester i.
- resp_ready  in  NREQ: requester i takes the result.
- resp_data  out  128: ciphertext, shared by all requesters.
- resp_err  out  1: result was aborted by the watchdog. Tied 0 without the macro.
- core_start  out  1: one-cycle launch pulse to the core.
- core_data  out  128: plaintext to the core, registered.
- core_key  out  128: key to the core, registered.
- core_rst_n  out  1: active-low reset to the core.
- core_done  in  1: core finished.
- core_out  in  128: core ciphertext, registered inside the core. Valid from the cycle after core_done.

## Operation
- The FSM has five states: IDLE, LAUNCH, BUSY, CAPTURE, RESP.
- IDLE:
  - If any req_valid is high, grant by round-robin starting at index ptr+1 mod NREQ.
  - Pulse req_ready[g] for that cycle.
  - Latch req_data/req_key of requester g into core_data/core_key, and record owner = g.
  - Go to LAUNCH.
- LAUNCH: core_start = 1 for exactly one cycle; go to BUSY.
- BUSY:
  - Wait for the first cycle with core_done = 1, then go to CAPTURE.
  - core_done is treated as a level; only its first high cycle is acted on.
- CAPTURE: resp_data <= core_out; resp_err <= 0; go to RESP.
- RESP:
  - resp_valid[owner] = 1, held with resp_data stable until resp_ready[owner] = 1.
  - On that handshake cycle: ptr <= owner, then go to IDLE.
  - resp_ready on any other index is ignored.
- core_data/core_key stay constant from LAUNCH until the FSM returns to IDLE.
- No new job is accepted until the response has been taken. There is exactly one job in flight.
- If req_valid drops before grant, the requester is simply not granted. Once granted, its data is already latched.
- Round-robin fairness: a requester that keeps req_valid high is granted within NREQ jobs.
- core_rst_n = 1 except as described under Configuration.

## Timing
- Reset (async assert, sync release):
  - FSM = IDLE, ptr = NREQ-1 (so index 0 wins first).
  - req_ready, resp_valid, resp_err, core_start = 0.
  - resp_data, core_data, core_key = 0.
  - core_rst_n = 0 while rst is high, 1 from the first edge after release.
- Acceptance is at cycle T. Then core_start is high at T+1, and BUSY begins at T+2.
- If core_done is first high at cycle D, CAPTURE is at D+1 and resp_valid rises at D+2.
- With resp_ready held high, the next acceptance is possible at D+3.
- Simultaneous requests: a single grant per IDLE cycle, round-robin order.
- core_done asserted while in LAUNCH is ignored. It is only sampled in BUSY.
- Reset mid-job: the job is dropped, no response is produced, and core_rst_n is forced low.

## Configuration
- AES_ARB_WATCHDOG_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without core_done, pulse core_rst_n = 0 for one cycle and go to CAPTURE with resp_err <= 1 and resp_data <= 0.
  - The response is then delivered normally.
- Not defined: no counter, BUSY waits indefinitely, and resp_err is tied to 0.

## Structure
- Package aes_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, BUSY, CAPTURE, RESP);
  - AES_W = 128;
  - the helper function for the req_data slice index.
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs are the request vector and ptr; outputs are a one-hot grant and its encoded index.

## Test plan
- Single job: req_valid[0] with FIPS-197 plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f, core model done after 11 cycles. Expect resp_valid[0] at D+2 with resp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, and core_start high exactly once.
- All four requests held high: grants occur in order 0,1,2,3,0. Each resp_valid goes to the matching index, and no overlap with core_start happens before the response is taken.
- resp_ready withheld for 20 cycles: resp_valid and resp_data hold stable, and req_ready stays 0 for all pending requesters.
- rst asserted in BUSY: all outputs return to their reset values immediately. After release, a new job from requester 0 completes correctly.
- AES_ARB_WATCHDOG_EN with TIMEOUT=16 and a core that never asserts done: core_rst_n is low for one cycle after 16 BUSY cycles, then the response arrives with resp_err=1 and resp_data=0.
- core_done pulsed during LAUNCH then deasserted: it is ignored, and the FSM completes on the later real done.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared types and helpers for the AES core arbiter: FSM state encoding,
// the AES block width, and the slice-offset helper for packed requester buses.
package aes_arb_pkg;

  localparam int AES_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    CAPTURE,
    RESP
  } state_t;

  // Bit offset of requester idx inside a packed NREQ*AES_W bus.
  function automatic int slice_lsb(input int idx);
    return idx * AES_W;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches from ptr+1 upward (mod NREQ)
// and returns the first asserted request as one-hot and as an index.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);

  localparam int IDX_W = $clog2(NREQ);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Rotating priority search; the requester just served has lowest priority.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(ptr) + k) % NREQ;
      cand_idx = cand[IDX_W-1:0];
      if (!grant_any && req[cand_idx]) begin
        grant_any       = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin scheduler sharing one iterative AES-128 core among NREQ
// requesters, with exactly one job in flight.
// Optional feature: define AES_ARB_WATCHDOG_EN to add a BUSY watchdog that
// resets the core after TIMEOUT cycles and returns an error response.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*AES_W-1:0] req_data,
  input  logic [NREQ*AES_W-1:0] req_key,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [AES_W-1:0]      resp_data,
  output logic                  resp_err,
  output logic                  core_start,
  output logic [AES_W-1:0]      core_data,
  output logic [AES_W-1:0]      core_key,
  output logic                  core_rst_n,
  input  logic                  core_done,
  input  logic [AES_W-1:0]      core_out
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int BASE_W = $clog2(NREQ * AES_W);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant_idx;
  logic [NREQ-1:0]    grant;
  logic               grant_any;
  logic               resp_take;
  logic [BASE_W-1:0]  sel_lsb;
  logic [AES_W-1:0]   cap_data;
  logic               core_rst_n_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel_lsb    = BASE_W'(slice_lsb(int'(grant_idx)));
  assign resp_take  = (state == RESP) && resp_ready[owner];
  assign core_rst_n = core_rst_n_q;

`ifdef AES_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_fired;
  logic             wd_timeout;
  logic             resp_err_q;

  assign wd_timeout = (state == BUSY) && !core_done && (wd_cnt == WD_LAST);
  assign cap_data   = wd_fired ? '0 : core_out;
  assign resp_err   = resp_err_q;

  // Watchdog: count BUSY cycles, pulse the core reset and flag the response on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt       <= '0;
      wd_fired     <= 1'b0;
      resp_err_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      core_rst_n_q <= !wd_timeout;
      if (state == LAUNCH) begin
        wd_cnt   <= '0;
        wd_fired <= 1'b0;
      end else if (state == BUSY) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
        if (wd_timeout) wd_fired <= 1'b1;
      end
      if (state == CAPTURE) resp_err_q <= wd_fired;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign cap_data = core_out;
  assign resp_err = 1'b0;

  // Core reset follows the arbiter reset, released on the first edge after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) core_rst_n_q <= 1'b0;
    else     core_rst_n_q <= 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; done is only honoured in BUSY, so a stray LAUNCH-cycle done is ignored.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_any) state_n = LAUNCH;
      LAUNCH:  state_n = BUSY;
      BUSY: begin
        if (core_done) state_n = CAPTURE;
`ifdef AES_ARB_WATCHDOG_EN
        else if (wd_timeout) state_n = CAPTURE;
`endif
      end
      CAPTURE: state_n = RESP;
      RESP:    if (resp_take) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore-style handshake outputs; req_ready is the live grant while IDLE.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    core_start = 1'b0;
    if (state == IDLE && !rst) req_ready = grant;
    if (state == RESP) resp_valid[owner] = 1'b1;
    if (state == LAUNCH) core_start = 1'b1;
  end

  // Job datapath: latch the granted pair, capture the result, advance the pointer on hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IDX_W'(NREQ - 1);
      owner     <= '0;
      core_data <= '0;
      core_key  <= '0;
      resp_data <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        owner     <= grant_idx;
        core_data <= req_data[sel_lsb +: AES_W];
        core_key  <= req_key[sel_lsb +: AES_W];
      end
      if (state == CAPTURE) resp_data <= cap_data;
      if (resp_take) ptr <= owner;
    end
  end

endmodule
